// File: rtl/fpu_pkg.sv
// Shared types for the FPU scheduler and the FPU adder it fronts.
package fpu_pkg;

   localparam int FPU_WORD_W = 32;

   // One-hot result status, produced by the FPU and passed through untouched.
   typedef enum logic [3:0] {
      OVERFLOW  = 4'b0001,
      UNDERFLOW = 4'b0010,
      EXACT     = 4'b0100,
      INEXACT   = 4'b1000
   } status_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } sched_state_t;

endpackage

// File: rtl/fpu_rr_scheduler_if.sv
// Request/response and FPU-side bus of the round-robin FPU scheduler.
// master = requesters + FPU, slave = scheduler.
interface fpu_rr_scheduler_if;
   import fpu_pkg::*;

   logic                  req0_valid;
   logic                  req0_ready;
   logic [FPU_WORD_W-1:0] req0_op_a;
   logic [FPU_WORD_W-1:0] req0_op_b;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [FPU_WORD_W-1:0] req1_op_a;
   logic [FPU_WORD_W-1:0] req1_op_b;

   logic                  rsp0_valid;
   logic                  rsp0_ready;
   logic                  rsp1_valid;
   logic                  rsp1_ready;
   logic [FPU_WORD_W-1:0] rsp_data;
   status_t               rsp_status;
   logic                  busy;

   logic [FPU_WORD_W-1:0] fpu_op_a;
   logic [FPU_WORD_W-1:0] fpu_op_b;
   logic [FPU_WORD_W-1:0] fpu_data;
   status_t               fpu_status;

   modport master (
      output req0_valid, req0_op_a, req0_op_b, req1_valid, req1_op_a, req1_op_b,
      output rsp0_ready, rsp1_ready, fpu_data, fpu_status,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_status,
      input  busy, fpu_op_a, fpu_op_b
   );

   modport slave (
      input  req0_valid, req0_op_a, req0_op_b, req1_valid, req1_op_a, req1_op_b,
      input  rsp0_ready, rsp1_ready, fpu_data, fpu_status,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_status,
      output busy, fpu_op_a, fpu_op_b
   );

endinterface

// File: rtl/fpu_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that was not served last.
module fpu_rr_pick (
   input  logic [1:0] valid,
   input  logic       rr_last,
   output logic       grant_id,
   output logic       grant_vld
);

   // Pick the winner from the current valid pair and the last-served id.
   always_comb begin
      grant_vld = |valid;
      grant_id  = 1'b0;
      case (valid)
         2'b10:   grant_id = 1'b1;
         2'b11:   grant_id = ~rr_last;
         default: grant_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one fixed-latency FPU adder between two requesters. One operation
// in flight at a time: accept, hold operands for FPU_LATENCY cycles, capture
// the result, and hold it until the granted requester takes it.
module fpu_rr_scheduler
   import fpu_pkg::*;
#(
   parameter  int FPU_LATENCY = 8,
   localparam int CNT_W       = $clog2(FPU_LATENCY + 1)
) (
   input logic               clock_100Khz,
   input logic               reset,
   fpu_rr_scheduler_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FPU_LATENCY - 1);

   sched_state_t          state;
   logic [CNT_W-1:0]      cnt;
   logic                  rr_last;
   logic                  gnt_id;
   logic [1:0]            rsp_vld;
   logic [FPU_WORD_W-1:0] op_a_q;
   logic [FPU_WORD_W-1:0] op_b_q;
   logic [FPU_WORD_W-1:0] rsp_data_q;
   status_t               rsp_status_q;

   logic                  pick_id;
   logic                  pick_vld;
   logic                  is_idle;
   logic                  rsp_hs;

   fpu_rr_pick u_pick (
      .valid     ({bus.req1_valid, bus.req0_valid}),
      .rr_last   (rr_last),
      .grant_id  (pick_id),
      .grant_vld (pick_vld)
   );

   // Ready only in IDLE and only to the picked requester, so a pick is an accept.
   assign is_idle        = (state == IDLE);
   assign bus.req0_ready = is_idle & pick_vld & ~pick_id;
   assign bus.req1_ready = is_idle & pick_vld &  pick_id;

   // Ready from the requester that is not being answered is masked off here.
   assign rsp_hs = |(rsp_vld & {bus.rsp1_ready, bus.rsp0_ready});

   assign bus.rsp0_valid = rsp_vld[0];
   assign bus.rsp1_valid = rsp_vld[1];
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.fpu_op_a   = op_a_q;
   assign bus.fpu_op_b   = op_b_q;
   assign bus.busy       = ~is_idle;

   // Scheduler FSM; operands are registered so the FPU never sees a request path.
   always_ff @(posedge clock_100Khz or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         cnt          <= '0;
         rr_last      <= 1'b1;
         gnt_id       <= 1'b0;
         rsp_vld      <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         rsp_data_q   <= '0;
         rsp_status_q <= EXACT;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  op_a_q <= pick_id ? bus.req1_op_a : bus.req0_op_a;
                  op_b_q <= pick_id ? bus.req1_op_b : bus.req0_op_b;
                  gnt_id <= pick_id;
                  cnt    <= '0;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  rsp_data_q   <= bus.fpu_data;
                  rsp_status_q <= bus.fpu_status;
                  rsp_vld      <= gnt_id ? 2'b10 : 2'b01;
                  state        <= RESPOND;
               end
            end
            RESPOND: begin
               if (rsp_hs) begin
                  rsp_vld <= '0;
                  rr_last <= gnt_id;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_rr_scheduler.sv
// Directed bench for fpu_rr_scheduler with an XOR FPU stub.
module tb_fpu_rr_scheduler;
   import fpu_pkg::*;

   localparam int L   = 8;
   localparam int PER = 10;

   logic clock_100Khz = 1'b0;
   logic reset        = 1'b0;
   int   checks       = 0;
   int   errors       = 0;
   int   gid  [6];
   int   gcyc [6];

   fpu_rr_scheduler_if bus ();

   fpu_rr_scheduler #(.FPU_LATENCY(L)) dut (
      .clock_100Khz (clock_100Khz),
      .reset        (reset),
      .bus          (bus)
   );

   always #(PER/2) clock_100Khz = ~clock_100Khz;

   // FPU stub: result is valid in the L-th cycle after the operands change,
   // in time for the capture edge at the end of that cycle.
   logic [31:0] fpu_pipe [L-1] = '{default: '0};
   always @(posedge clock_100Khz) begin
      fpu_pipe[0] <= bus.fpu_op_a ^ bus.fpu_op_b;
      for (int i = 1; i < L-1; i++) fpu_pipe[i] <= fpu_pipe[i-1];
   end
   assign bus.fpu_data   = fpu_pipe[L-2];
   assign bus.fpu_status = INEXACT;

   initial begin
      #(PER*5000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock_100Khz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}
   function automatic logic [31:0] outs();
      return {27'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid, bus.busy};
   endfunction

   // Steps until the expected response valid rises (bounded) and checks it.
   task automatic wait_rsp(input int who, input int exp_n, input logic [31:0] exp_data,
                           input string tag);
      int n     = 0;
      bit other = 0;
      bit got   = 0;
      while (!got && n < 40) begin
         step();
         n++;
         if (who == 0 ? bus.rsp1_valid : bus.rsp0_valid) other = 1;
         got = (who == 0) ? bus.rsp0_valid : bus.rsp1_valid;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_n));
      chk({tag, " data"}, bus.rsp_data, exp_data);
      chk({tag, " status"}, 32'(bus.rsp_status), 32'(INEXACT));
      chk({tag, " other rsp"}, 32'(other), 32'd0);
   endtask

   task automatic take(input int who);
      if (who == 0) bus.rsp0_ready = 1'b1;
      else          bus.rsp1_ready = 1'b1;
      step();
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
   endtask

   // Full single operation from IDLE: present, accept, wait, take.
   task automatic run_op(input int exp_id, input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1, input string tag);
      bus.req0_valid = v0; bus.req0_op_a = a0; bus.req0_op_b = b0;
      bus.req1_valid = v1; bus.req1_op_a = a1; bus.req1_op_b = b1;
      #1;
      chk({tag, " ready"}, 32'({bus.req1_ready, bus.req0_ready}),
          (exp_id == 1) ? 32'd2 : 32'd1);
      step();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      #1;
      chk({tag, " wait outs"}, outs(), 32'h01);
      wait_rsp(exp_id, L, (exp_id == 1) ? (a1 ^ b1) : (a0 ^ b0), tag);
      take(exp_id);
      #1;
      chk({tag, " done outs"}, outs(), 32'h00);
   endtask

   initial begin
      int n;
      int cyc;
      int k;
      bit seen;
      bus.req0_valid = 0; bus.req0_op_a = 0; bus.req0_op_b = 0;
      bus.req1_valid = 0; bus.req1_op_a = 0; bus.req1_op_b = 0;
      bus.rsp0_ready = 0; bus.rsp1_ready = 0;

      // Reset state
      repeat (2) step();
      chk("reset outs", outs(), 32'h00);
      chk("reset status", 32'(bus.rsp_status), 32'(EXACT));
      chk("reset op_a", bus.fpu_op_a, 32'h0);
      chk("reset data", bus.rsp_data, 32'h0);
      reset = 1'b1;
      step();
      chk("post-reset outs", outs(), 32'h00);

      // Tie after reset: req0 first, then req1
      run_op(0, 1, 1, 32'h40490FDB, 32'h3F800000, 32'hA5A5A5A5, 32'h0000FFFF, "tie1 r0");
      run_op(1, 0, 1, 32'h40490FDB, 32'h3F800000, 32'hA5A5A5A5, 32'h0000FFFF, "tie1 r1");

      // Single op on req0, then req1 alone to leave rr_last = 1
      run_op(0, 1, 0, 32'h3FE00000, 32'h00000001, 32'h0, 32'h0, "single");
      run_op(1, 0, 1, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0000FFFF, "solo r1");

      // Tie again: req0 wins since rr_last = 1
      run_op(0, 1, 1, 32'h40490FDB, 32'h3F800000, 32'hA5A5A5A5, 32'h0000FFFF, "tie2 r0");
      run_op(1, 0, 1, 32'h40490FDB, 32'h3F800000, 32'hA5A5A5A5, 32'h0000FFFF, "tie2 r1");

      // Fairness: both held valid, responses taken immediately
      bus.req0_op_a = 32'h11110000; bus.req0_op_b = 32'h00002222;
      bus.req1_op_a = 32'hCAFE0000; bus.req1_op_b = 32'h0000BABE;
      bus.req0_valid = 1; bus.req1_valid = 1;
      bus.rsp0_ready = 1; bus.rsp1_ready = 1;
      n = 0; cyc = 0;
      while (n < 6 && cyc < 100) begin
         #1;
         if (bus.req0_ready || bus.req1_ready) begin
            gid[n]  = int'(bus.req1_ready);
            gcyc[n] = cyc;
            n++;
         end
         if (bus.rsp0_valid) chk("fair rsp0 data", bus.rsp_data, 32'h11112222);
         if (bus.rsp1_valid) chk("fair rsp1 data", bus.rsp_data, 32'hCAFEBABE);
         step();
         cyc++;
      end
      bus.req0_valid = 0; bus.req1_valid = 0;
      k = 0;
      while (bus.busy && k < 40) begin
         step();
         k++;
      end
      bus.rsp0_ready = 0; bus.rsp1_ready = 0;
      chk("fair drain busy", 32'(bus.busy), 32'd0);
      chk("fair grant count", 32'(n), 32'd6);
      for (int i = 0; i < 6; i++) begin
         chk("fair grant id", 32'(gid[i]), 32'(i % 2));
         if (i > 0) chk("fair issue gap", 32'(gcyc[i] - gcyc[i-1]), 32'(L + 2));
      end

      // Back-pressure on rsp1; req0 waits and rsp0_ready is ignored
      bus.req1_valid = 1; bus.req1_op_a = 32'h12345678; bus.req1_op_b = 32'h0F0F0F0F;
      #1;
      chk("bp ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd2);
      step();
      bus.req1_valid = 0;
      wait_rsp(1, L, 32'h1D3B5977, "bp");
      bus.req0_valid = 1; bus.req0_op_a = 32'hDEADBEEF; bus.req0_op_b = 32'h01010101;
      bus.rsp0_ready = 1;
      #1;
      for (int i = 0; i < 20; i++) begin
         chk("bp hold outs", outs(), 32'h03);
         chk("bp hold data", bus.rsp_data, 32'h1D3B5977);
         step();
      end
      chk("bp hold status", 32'(bus.rsp_status), 32'(INEXACT));
      bus.rsp0_ready = 0;
      bus.rsp1_ready = 1;
      step();
      bus.rsp1_ready = 0;
      #1;
      chk("bp release outs", outs(), 32'h10);

      // Withdrawn req1 pulse while req0 is in WAIT
      step();
      bus.req0_valid = 0;
      bus.req1_valid = 1; bus.req1_op_a = 32'hFFFFFFFF; bus.req1_op_b = 32'h0;
      #1;
      chk("wd pulse outs", outs(), 32'h01);
      step();
      bus.req1_valid = 0;
      wait_rsp(0, L - 1, 32'hDFACBFEE, "wd");
      take(0);
      #1;
      chk("wd done outs", outs(), 32'h00);
      chk("wd op_a held", bus.fpu_op_a, 32'hDEADBEEF);
      repeat (3) step();
      chk("wd no phantom", outs(), 32'h00);

      // Reset in the middle of WAIT aborts the operation
      bus.req0_valid = 1; bus.req0_op_a = 32'h55555555; bus.req0_op_b = 32'hAAAAAAAA;
      #1;
      chk("abort ready", 32'({bus.req1_ready, bus.req0_ready}), 32'd1);
      step();
      bus.req0_valid = 0;
      repeat (3) step();
      chk("abort wait outs", outs(), 32'h01);
      reset = 1'b0;
      #1;
      chk("abort reset outs", outs(), 32'h00);
      chk("abort reset status", 32'(bus.rsp_status), 32'(EXACT));
      chk("abort reset op_a", bus.fpu_op_a, 32'h0);
      chk("abort reset data", bus.rsp_data, 32'h0);
      step();
      reset = 1'b1;
      seen = 0;
      repeat (15) begin
         step();
         if (outs() != 32'h0) seen = 1;
      end
      chk("abort no rsp", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
